// File: rtl/svm_weight_loader.sv
// SVM weight/bias loader: assembles 2100-bit rows from a 256-bit stream.
// Optional macro SVM_LOAD_READBACK_EN adds a per-row readback check.
module svm_weight_loader #(
  parameter int AXIS_TDATA_W = 256,
  parameter int ROW_W        = 2100,
  parameter int ROW_NUM      = 36,
  parameter int ADDR_W       = 6,
  parameter int BIAS_W       = 20
) (
  input  logic                    s_aclk,
  input  logic                    s_aresetn,
  input  logic                    cfg_start_i,
  input  logic [AXIS_TDATA_W-1:0] s_tdata_i,
  input  logic                    s_tlast_i,
  input  logic                    s_tvalid_i,
  output logic                    s_tready_o,
  output logic [ADDR_W-1:0]       addr_a_o,
  output logic                    write_en_o,
  output logic [ROW_W-1:0]        data_a_o,
  input  logic [ROW_W-1:0]        data_a_i,
  output logic [BIAS_W-1:0]       bias_o,
  output logic                    b_load_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);

  localparam int BEATS =
    (ROW_W + AXIS_TDATA_W - 1) / AXIS_TDATA_W;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int BUF_W  = (BEATS - 1) * AXIS_TDATA_W;
  localparam int TAIL_W = ROW_W - BUF_W;

  localparam logic [BEAT_W-1:0] LAST_BEAT =
    BEAT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW =
    ADDR_W'(ROW_NUM - 1);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
`ifdef SVM_LOAD_READBACK_EN
    RDADDR,
    CHECK,
`endif
    BIAS,
    DRAIN
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [BEAT_W-1:0]   beat_q;
  logic [ADDR_W-1:0]   row_q;
  logic [BUF_W-1:0]    buf_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ROW_W-1:0]    data_q;
  logic [BIAS_W-1:0]   bias_q;
  logic                b_load_q;
  logic                done_q;
  logic                err_q;

  logic ready;
  logic we;
  logic acc;
  logic start;
  logic store;
  logic ld_row;
  logic row_adv;
  logic ld_bias;
  logic set_err;
  logic set_done;
  logic last_row;

  assign last_row = (row_q == LAST_ROW);

`ifndef SVM_LOAD_READBACK_EN
  logic unused_rd;
  assign unused_rd = ^data_a_i;
`endif

  // Next-state decode and per-cycle control strobes
  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    we       = 1'b0;
    start    = 1'b0;
    store    = 1'b0;
    ld_row   = 1'b0;
    row_adv  = 1'b0;
    ld_bias  = 1'b0;
    set_err  = 1'b0;
    set_done = 1'b0;
    acc      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_start_i) begin
          start   = 1'b1;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        ready = 1'b1;
        acc   = s_tvalid_i;
        if (acc) begin
          if (s_tlast_i) begin
            set_err = 1'b1;
            state_d = IDLE;
          end else if (beat_q == LAST_BEAT) begin
            ld_row  = 1'b1;
            state_d = WRITE;
          end else begin
            store = 1'b1;
          end
        end
      end
      WRITE: begin
        we = 1'b1;
`ifdef SVM_LOAD_READBACK_EN
        state_d = RDADDR;
`else
        row_adv = 1'b1;
        state_d = last_row ? BIAS : COLLECT;
`endif
      end
`ifdef SVM_LOAD_READBACK_EN
      RDADDR: begin
        state_d = CHECK;
      end
      CHECK: begin
        set_err = (data_a_i != data_q);
        row_adv = 1'b1;
        state_d = last_row ? BIAS : COLLECT;
      end
`endif
      BIAS: begin
        ready = 1'b1;
        acc   = s_tvalid_i;
        if (acc) begin
          ld_bias = 1'b1;
          if (s_tlast_i) begin
            set_done = 1'b1;
            state_d  = IDLE;
          end else begin
            set_err = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        ready = 1'b1;
        acc   = s_tvalid_i;
        if (acc && s_tlast_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Beat and row counters
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      beat_q <= '0;
      row_q  <= '0;
    end else if (start) begin
      beat_q <= '0;
      row_q  <= '0;
    end else if (row_adv) begin
      beat_q <= '0;
      row_q  <= row_q + ADDR_W'(1);
    end else if (store) begin
      beat_q <= beat_q + BEAT_W'(1);
    end
  end

  // Row assembly buffer; the final beat goes straight to data_q
  always_ff @(posedge s_aclk) begin
    for (int k = 0; k < BEATS - 1; k++) begin
      if (store && beat_q == BEAT_W'(k)) begin
        buf_q[k*AXIS_TDATA_W +: AXIS_TDATA_W] <= s_tdata_i;
      end
    end
  end

  // RAM address/data and bias registers, held between strobes
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      addr_q   <= '0;
      data_q   <= '0;
      bias_q   <= '0;
      b_load_q <= 1'b0;
    end else begin
      b_load_q <= ld_bias;
      if (ld_row) begin
        addr_q <= row_q;
        data_q <= {s_tdata_i[TAIL_W-1:0], buf_q};
      end
      if (ld_bias) begin
        bias_q <= s_tdata_i[BIAS_W-1:0];
      end
    end
  end

  // Sticky completion and error flags, cleared on a new load
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (start) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (set_err) begin
        err_q <= 1'b1;
      end
      if (set_done) begin
        done_q <= 1'b1;
      end
    end
  end

  assign s_tready_o = ready;
  assign write_en_o = we;
  assign addr_a_o   = addr_q;
  assign data_a_o   = data_q;
  assign bias_o     = bias_q;
  assign b_load_o   = b_load_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_svm_weight_loader.sv
// Scoreboard bench for svm_weight_loader.
// Build with SVM_LOAD_READBACK_EN to also exercise readback.
module tb_svm_weight_loader;

  localparam int DW = 256;
  localparam int RW = 2100;
  localparam int RN = 36;
  localparam int AW = 6;
  localparam int BW = 20;

  logic          clk;
  logic          rst_n;
  logic          cfg_start;
  logic [DW-1:0] tdata;
  logic          tlast;
  logic          tvalid;
  logic          tready;
  logic [AW-1:0] addr;
  logic          we;
  logic [RW-1:0] wdata;
  logic [RW-1:0] rdata;
  logic [BW-1:0] bias;
  logic          bload;
  logic          busy;
  logic          done;
  logic          err;

  svm_weight_loader dut (
    .s_aclk      (clk),
    .s_aresetn   (rst_n),
    .cfg_start_i (cfg_start),
    .s_tdata_i   (tdata),
    .s_tlast_i   (tlast),
    .s_tvalid_i  (tvalid),
    .s_tready_o  (tready),
    .addr_a_o    (addr),
    .write_en_o  (we),
    .data_a_o    (wdata),
    .data_a_i    (rdata),
    .bias_o      (bias),
    .b_load_o    (bload),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nvec;
  int nerr;
  int nwr;
  int nbl;
  bit rdy_chk;
  bit corrupt;

  logic [RW-1:0] exp_d[$];
  logic [AW-1:0] exp_a[$];
  logic [BW-1:0] exp_b[$];

  logic [RW-1:0] mem [64];

  // Simple RAM: synchronous write, registered read
  always @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr] ^
      ((corrupt && addr == 6'd3) ? RW'(128) : RW'(0));
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_pat(int r, int k);
    return {8{r[15:0], k[15:0]}};
  endfunction

  function automatic logic [RW-1:0] row_pat(int r);
    logic [2303:0] f;
    for (int k = 0; k < 9; k++) f[k*DW +: DW] = beat_pat(r, k);
    return f[RW-1:0];
  endfunction

  logic [RW-1:0] m_d;
  logic [2111:0] m_g;
  logic [2111:0] m_e;

  // Output monitor: pops the scoreboard on each strobe
  always @(negedge clk) begin
    if (rst_n) begin
      if (we) begin
        nwr++;
        if (exp_a.size() == 0) begin
          chk("wr_unexp", 1, 0);
        end else begin
          chk("waddr", 64'(addr), 64'(exp_a.pop_front()));
          m_d = exp_d.pop_front();
          m_g = {12'b0, wdata};
          m_e = {12'b0, m_d};
          for (int j = 0; j < 33; j++)
            chk($sformatf("wdata_a%0d_c%0d", addr, j),
                m_g[j*64 +: 64], m_e[j*64 +: 64]);
        end
      end
      if (bload) begin
        nbl++;
        if (exp_b.size() == 0) chk("bl_unexp", 1, 0);
        else chk("bias", 64'(bias), 64'(exp_b.pop_front()));
      end
`ifndef SVM_LOAD_READBACK_EN
      if (rdy_chk && busy) chk("rdy_vs_wr", 64'(tready), 64'(!we));
`endif
    end
  end

  task automatic send_beat(input logic [DW-1:0] d,
                           input bit last, input bit gaps);
    bit rdy;
    int n;
    n = 0;
    while (gaps && $urandom_range(1, 0) == 1 && n < 8) begin
      tvalid = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    tdata  = d;
    tlast  = last;
    tvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rdy = tready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 200);
    if (!rdy) chk("beat_timeout", 0, 1);
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 100);
    if (busy) chk("idle_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string t);
    chk({t, "_rdy"},   64'(tready), 0);
    chk({t, "_we"},    64'(we), 0);
    chk({t, "_addr"},  64'(addr), 0);
    chk({t, "_data"},  64'(|wdata), 0);
    chk({t, "_bias"},  64'(bias), 0);
    chk({t, "_bload"}, 64'(bload), 0);
    chk({t, "_busy"},  64'(busy), 0);
    chk({t, "_done"},  64'(done), 0);
    chk({t, "_err"},   64'(err), 0);
  endtask

  logic [DW-1:0] bias_beat;

  task automatic run_load(input bit gaps, input bit blast,
                          input bit poke);
    nwr = 0;
    nbl = 0;
    pulse_start();
    for (int r = 0; r < RN; r++) begin
      for (int k = 0; k < 9; k++) begin
        if (k == 8) begin
          exp_a.push_back(AW'(r));
          exp_d.push_back(row_pat(r));
        end
        send_beat(beat_pat(r, k), 1'b0, gaps);
      end
      if (poke && r == 5) pulse_start();
    end
    exp_b.push_back(20'h01234);
    send_beat(bias_beat, blast, gaps);
    if (!blast) begin
      for (int i = 0; i < 3; i++)
        send_beat({8{32'h5a5a0000 | i}}, i == 2, gaps);
    end
    wait_idle();
    chk("wr_count", 64'(nwr), RN);
    chk("bl_count", 64'(nbl), 1);
    chk("q_left", 64'(exp_a.size() + exp_b.size()), 0);
    chk("busy_end", 64'(busy), 0);
  endtask

  initial begin
    nvec      = 0;
    nerr      = 0;
    rdy_chk   = 1'b0;
    corrupt   = 1'b0;
    rst_n     = 1'b0;
    cfg_start = 1'b0;
    tdata     = '0;
    tlast     = 1'b0;
    tvalid    = 1'b0;
    bias_beat = {8{32'hdeadbeef}};
    bias_beat[19:0] = 20'h01234;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // clean load
    run_load(1'b0, 1'b1, 1'b0);
    chk("clean_done", 64'(done), 1);
    chk("clean_err", 64'(err), 0);

    // stalls, plus a start pulse mid-load that must be ignored
    rdy_chk = 1'b1;
    run_load(1'b1, 1'b1, 1'b1);
    rdy_chk = 1'b0;
    chk("stall_done", 64'(done), 1);
    chk("stall_err", 64'(err), 0);

    // early tlast on beat 4 of row 2
    nwr = 0;
    nbl = 0;
    pulse_start();
    chk("start_done_clr", 64'(done), 0);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 9; k++) begin
        if (r == 2 && k > 4) break;
        if (k == 8) begin
          exp_a.push_back(AW'(r));
          exp_d.push_back(row_pat(r));
        end
        send_beat(beat_pat(r, k), r == 2 && k == 4, 1'b0);
      end
    end
    wait_idle();
    chk("early_wr", 64'(nwr), 2);
    chk("early_bl", 64'(nbl), 0);
    chk("early_err", 64'(err), 1);
    chk("early_done", 64'(done), 0);
    pulse_start();
    chk("err_clr", 64'(err), 0);
    chk("restart_busy", 64'(busy), 1);
    send_beat(beat_pat(0, 0), 1'b1, 1'b0);
    wait_idle();
    chk("abort_err", 64'(err), 1);

    // missing tlast on bias beat, then 3 drained beats
    run_load(1'b0, 1'b0, 1'b0);
    chk("miss_err", 64'(err), 1);
    chk("miss_done", 64'(done), 0);

    // reset during row 10, beat 5
    nwr = 0;
    pulse_start();
    for (int r = 0; r < 11; r++) begin
      for (int k = 0; k < 9; k++) begin
        if (r == 10 && k == 5) break;
        if (k == 8) begin
          exp_a.push_back(AW'(r));
          exp_d.push_back(row_pat(r));
        end
        send_beat(beat_pat(r, k), 1'b0, 1'b0);
      end
    end
    chk("pre_rst_wr", 64'(nwr), 10);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_load(1'b0, 1'b1, 1'b0);
    chk("post_rst_done", 64'(done), 1);
    chk("post_rst_err", 64'(err), 0);

`ifdef SVM_LOAD_READBACK_EN
    // RAM returns row 3 with bit 7 flipped
    corrupt = 1'b1;
    run_load(1'b0, 1'b1, 1'b0);
    corrupt = 1'b0;
    chk("rb_err", 64'(err), 1);
    chk("rb_done", 64'(done), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
